// File: rtl/ram8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram8_pkg
// Description : Shared geometry constants for the ram8 storage stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ram8_pkg;
    localparam int unsigned C_ADDR_W = 3;
    localparam int unsigned C_WORDS  = 1 << C_ADDR_W;
    localparam int unsigned C_DATA_W = 16;
endpackage : ram8_pkg
`default_nettype wire

// File: rtl/mux8way16.sv
`default_nettype none
// ============================================================================
// Module      : Mux8way16
// Description : 8-way 16-bit multiplexer, out = d[sel].
// Revision    : 1.0 - initial release
// ============================================================================
module Mux8way16 (
    input  logic [2:0]  sel,
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    input  logic [15:0] d2,
    input  logic [15:0] d3,
    input  logic [15:0] d4,
    input  logic [15:0] d5,
    input  logic [15:0] d6,
    input  logic [15:0] d7,
    output logic [15:0] out
);

    always_comb begin
        out = d0;
        case (sel)
            3'd0:    out = d0;
            3'd1:    out = d1;
            3'd2:    out = d2;
            3'd3:    out = d3;
            3'd4:    out = d4;
            3'd5:    out = d5;
            3'd6:    out = d6;
            3'd7:    out = d7;
            default: out = d0;
        endcase
    end

endmodule : Mux8way16
`default_nettype wire

// File: rtl/register16.sv
`default_nettype none
// ============================================================================
// Module      : register16
// Description : 16-bit load-enabled register with asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module register16
    import ram8_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [C_DATA_W-1:0] in,
    output logic [C_DATA_W-1:0] out
);

    logic [C_DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= in;
        end
    end

    assign out = r_q;

endmodule : register16
`default_nettype wire

// File: rtl/ram8.sv
`default_nettype none
// ============================================================================
// Module      : ram8
// Description : Eight-word 16-bit RAM; registered storage, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module ram8
    import ram8_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    in,
    input  logic                load,
    input  logic [C_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]    out
);

    logic [C_WORDS-1:0]  w_ld;
    logic [C_DATA_W-1:0] w_word [C_WORDS];

    // One-hot decode of the address, gated by load (8-way DMux of load).
    always_comb begin
        w_ld          = '0;
        w_ld[address] = load;
    end

    generate
        for (genvar gi = 0; gi < C_WORDS; gi++) begin : g_word
            register16 u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (w_ld[gi]),
                .in    (in),
                .out   (w_word[gi])
            );
        end
    endgenerate

    // Read port sees register outputs only; no bypass of in.
    Mux8way16 u_mux (
        .sel (address),
        .d0  (w_word[0]),
        .d1  (w_word[1]),
        .d2  (w_word[2]),
        .d3  (w_word[3]),
        .d4  (w_word[4]),
        .d5  (w_word[5]),
        .d6  (w_word[6]),
        .d7  (w_word[7]),
        .out (out)
    );

endmodule : ram8
`default_nettype wire

// File: tb/tb_ram8.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram8
// Description : Directed self-checking bench for ram8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram8;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic [15:0] out;

    int          total;
    int          bad;
    logic [15:0] model [8];

    ram8 #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, landing 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        model[a] = d;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), out, model[i]);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        load    = 1'b1;
        in      = 16'hFFFF;
        address = 3'd0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;

        // Reset held with load asserted: every address reads zero.
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            #1;
            check($sformatf("reset_sweep[%0d]", i), out, 16'h0000);
        end

        load  = 1'b0;
        tick();
        rst_n = 1'b1;

        // Write/readback with distinct pattern per word.
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            v = 16'(16'h1111 * i + 16'h0A0A);
            write_word(3'(i), v);
        end
        read_all("readback");
        check("readback_w7_const", model[7], 16'h8181);

        // Same-cycle read shows old data, new data after the edge.
        write_word(3'd3, 16'h00FF);
        address = 3'd3;
        in      = 16'hBEEF;
        load    = 1'b1;
        #1;
        check("same_cycle_before", out, 16'h00FF);
        tick();
        load = 1'b0;
        model[3] = 16'hBEEF;
        check("same_cycle_after", out, 16'hBEEF);

        // Hold without load on every address for 10 cycles.
        write_word(3'd5, 16'h1234);
        in   = 16'hFFFF;
        load = 1'b0;
        for (int c = 0; c < 10; c++) begin
            address = 3'(c);
            tick();
            check($sformatf("hold_cyc%0d", c), out, model[c % 8]);
        end
        address = 3'd5;
        #1;
        check("hold_w5", out, 16'h1234);
        read_all("hold_all");

        // Async reset between edges takes effect without a clock edge.
        address = 3'd5;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", out, 16'h0000);
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        tick();
        rst_n = 1'b1;
        read_all("after_reset");

        // Reset released at the write edge: that edge performs no write.
        rst_n   = 1'b0;
        load    = 1'b1;
        address = 3'd7;
        in      = 16'hAAAA;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("coincide_no_write", out, 16'h0000);
        tick();
        load = 1'b0;
        check("next_edge_write", out, 16'hAAAA);
        model[7] = 16'hAAAA;
        read_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ram8
`default_nettype wire
